// File: rtl/operation_pkg.sv
// Shared types and constants for the operation engine: opcodes, instruction format,
// widths and the fixed program ROM.
package operation_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned PROG_DEPTH = 8;
  localparam int unsigned PC_W       = $clog2(PROG_DEPTH);

  typedef enum logic [2:0] {
    OpLoad = 3'd0,
    OpAdd  = 3'd1,
    OpSub  = 3'd2,
    OpAnd  = 3'd3,
    OpOr   = 3'd4,
    OpXor  = 3'd5,
    OpShl  = 3'd6,
    OpShr  = 3'd7
  } opcode_e;

  typedef struct packed {
    opcode_e             opcode;
    logic [DATA_W-1:0]   imm;
  } instr_t;

  // ADD at pc1 and SUB at pc3 intentionally wrap past 8 bits.
  localparam instr_t PROG_ROM [PROG_DEPTH] = '{
    '{opcode: OpLoad, imm: 8'h05},
    '{opcode: OpAdd,  imm: 8'hFE},
    '{opcode: OpShl,  imm: 8'h00},
    '{opcode: OpSub,  imm: 8'h07},
    '{opcode: OpXor,  imm: 8'h0F},
    '{opcode: OpOr,   imm: 8'h0A},
    '{opcode: OpAnd,  imm: 8'h3C},
    '{opcode: OpShr,  imm: 8'h00}
  };

endpackage

// File: rtl/operation_alu.sv
// Combinational ALU: computes the next accumulator value from opcode, acc and imm.
// Carries, borrows and shifted-out bits are dropped; there are no flags.
module operation_alu
  import operation_pkg::*;
(
  input  opcode_e            opcode_i,
  input  logic [DATA_W-1:0]  acc_i,
  input  logic [DATA_W-1:0]  imm_i,
  output logic [DATA_W-1:0]  result_o
);

  always_comb begin
    result_o = acc_i;
    unique case (opcode_i)
      OpLoad: result_o = imm_i;
      OpAdd:  result_o = acc_i + imm_i;
      OpSub:  result_o = acc_i - imm_i;
      OpAnd:  result_o = acc_i & imm_i;
      OpOr:   result_o = acc_i | imm_i;
      OpXor:  result_o = acc_i ^ imm_i;
      OpShl:  result_o = {acc_i[DATA_W-2:0], 1'b0};
      OpShr:  result_o = {1'b0, acc_i[DATA_W-1:1]};
      default: result_o = acc_i;
    endcase
  end

endmodule

// File: rtl/operation_unit.sv
// Sequenced 8-bit accumulator engine: runs the fixed ROM program one instruction
// per clock, wrapping forever; the accumulator is visible on po_a.
module operation_unit
  import operation_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  output logic [DATA_W-1:0] po_a
);

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  instr_t            instr;

  assign instr = PROG_ROM[pc_q];
  assign pc_d  = pc_q + PC_W'(1);

  operation_alu u_alu (
    .opcode_i (instr.opcode),
    .acc_i    (acc_q),
    .imm_i    (instr.imm),
    .result_o (acc_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= '0;
      acc_q <= '0;
    end else begin
      pc_q  <= pc_d;
      acc_q <= acc_d;
    end
  end

  assign po_a = acc_q;

endmodule

// File: tb/tb_operation_unit.sv
// Randomized self-checking bench for operation_unit and its ALU against a
// sequence-level reference model.
module tb_operation_unit;
  import operation_pkg::*;

  logic       clk;
  logic       reset;
  logic [7:0] po_a;

  opcode_e    alu_op;
  logic [7:0] alu_acc;
  logic [7:0] alu_imm;
  logic [7:0] alu_res;

  int n_cmp = 0;
  int n_bad = 0;

  // Program output sequence as stated for the block, one entry per executed edge.
  logic [7:0] exp_seq [8] = '{8'h05, 8'h03, 8'h06, 8'hFF, 8'hF0, 8'hFA, 8'h38, 8'h1C};
  int edges_since_release = 0;

  operation_unit dut (
    .clk   (clk),
    .reset (reset),
    .po_a  (po_a)
  );

  operation_alu alu (
    .opcode_i (alu_op),
    .acc_i    (alu_acc),
    .imm_i    (alu_imm),
    .result_o (alu_res)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] unit_model(input int k);
    return (k == 0) ? 8'h00 : exp_seq[(k - 1) % 8];
  endfunction

  function automatic logic [7:0] alu_model(input int op, input int a, input int b);
    int r;
    case (op)
      0: r = b;
      1: r = (a + b) % 256;
      2: r = (a - b + 256) % 256;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = (a * 2) % 256;
      default: r = a / 2;
    endcase
    return 8'(r);
  endfunction

  // One rising edge while out of reset, checked shortly after.
  task automatic run_edge(input string tag);
    @(posedge clk);
    #1;
    edges_since_release++;
    check(tag, po_a, unit_model(edges_since_release));
  endtask

  task automatic release_between_edges();
    @(negedge clk);
    reset = 1'b0;
    edges_since_release = 0;
  endtask

  logic [7:0] alu_dir [8] = '{8'h0F, 8'h90, 8'h72, 8'h01, 8'h8F, 8'h8E, 8'h02, 8'h40};

  initial begin
    reset   = 1'b1;
    alu_op  = OpLoad;
    alu_acc = 8'h00;
    alu_imm = 8'h00;

    // Reset hold: output stays zero across edges.
    #1;
    check("reset_initial", po_a, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("reset_hold_%0d", i), po_a, 8'h00);
    end

    // Three full program periods; covers both wraps and the carry/borrow edges.
    release_between_edges();
    check("released_no_edge", po_a, 8'h00);
    for (int i = 1; i <= 24; i++) run_edge($sformatf("seq_edge_%0d", i));

    // Mid-program asynchronous reset while po_a = FF.
    reset = 1'b1;
    @(negedge clk);
    release_between_edges();
    for (int i = 1; i <= 4; i++) run_edge($sformatf("pre_mid_edge_%0d", i));
    @(negedge clk);
    check("mid_before_reset", po_a, 8'hFF);
    reset = 1'b1;
    #1;
    check("mid_async_clear", po_a, 8'h00);
    @(posedge clk);
    #1;
    check("mid_hold_edge", po_a, 8'h00);
    release_between_edges();
    for (int i = 1; i <= 8; i++) run_edge($sformatf("restart_edge_%0d", i));

    // Random run lengths interrupted by resets at random points in the low phase.
    for (int r = 0; r < 20; r++) begin
      int len;
      int hold;
      len  = $urandom_range(1, 20);
      hold = $urandom_range(1, 3);
      for (int i = 0; i < len; i++) run_edge($sformatf("rnd%0d_edge", r));
      @(negedge clk);
      #($urandom_range(1, 3));
      reset = 1'b1;
      #1;
      check($sformatf("rnd%0d_async", r), po_a, 8'h00);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        #1;
        check($sformatf("rnd%0d_hold", r), po_a, 8'h00);
      end
      release_between_edges();
    end
    for (int i = 0; i < 9; i++) run_edge("tail_edge");

    // ALU directed vector from acc=81, imm=0F.
    alu_acc = 8'h81;
    alu_imm = 8'h0F;
    for (int op = 0; op < 8; op++) begin
      alu_op = opcode_e'(op);
      #1;
      check($sformatf("alu_dir_op%0d", op), alu_res, alu_dir[op]);
    end

    // ALU random vectors.
    for (int i = 0; i < 64; i++) begin
      int op;
      op      = $urandom_range(0, 7);
      alu_op  = opcode_e'(op);
      alu_acc = 8'($urandom);
      alu_imm = 8'($urandom);
      #1;
      check($sformatf("alu_rnd_op%0d", op), alu_res,
            alu_model(op, int'(alu_acc), int'(alu_imm)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/operation_unit.md
# operation_unit

Self-contained sequenced 8-bit arithmetic/logic engine with no data inputs. A fixed 8-entry instruction program runs continuously against an 8-bit accumulator, one instruction per clock, wrapping forever. The accumulator is exposed on `po_a`. The block serves as a standalone datapath demonstrator and smoke-test target at the top of the operation subsystem.

## Interface
- No parameters. Width (8), program depth (8) and program contents are fixed constants.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `po_a` output 8: accumulator value, registered, driven directly from the accumulator flop.

## Operation
- State consists of:
  - `pc`: 3-bit program counter.
  - `acc`: 8-bit accumulator, with `po_a = acc`.
- Each instruction has a 3-bit opcode and an 8-bit immediate `imm`.
- Opcode encoding:
  - LOAD=0: acc←imm
  - ADD=1: acc←acc+imm, mod 256
  - SUB=2: acc←acc−imm, mod 256
  - AND=3: acc←acc&imm
  - OR=4: acc←acc|imm
  - XOR=5: acc←acc^imm
  - SHL=6: acc←acc<<1, zero fill
  - SHR=7: acc←acc>>1, logical, zero fill
- SHL and SHR ignore `imm`.
- Carry, borrow and shifted-out bits are discarded. There are no flags.
- Fixed program:
  - pc0: LOAD 0x05
  - pc1: ADD 0xFE
  - pc2: SHL
  - pc3: SUB 0x07
  - pc4: XOR 0x0F
  - pc5: OR 0x0A
  - pc6: AND 0x3C
  - pc7: SHR
- Each rising edge outside reset executes the instruction at `pc`, updates `acc`, then sets pc←pc+1. The counter wraps 7→0.
- Resulting `po_a` sequence, repeating with period 8: 05, 03, 06, FF, F0, FA, 38, 1C, then 05, …
- The ADD at pc1 and the SUB at pc3 deliberately exercise wrap-around.

## Timing
- Reset (asynchronous):
  - Asserting `reset` immediately forces pc=0 and acc=0x00, so `po_a`=0x00 without waiting for a clock edge.
  - This holds for as long as `reset` is high.
- Release:
  - The first rising edge with `reset` low executes pc0, so `po_a`=0x05 after that edge.
  - Latency from instruction fetch to `po_a` is exactly one clock.
  - `po_a` changes only on rising edges or on reset assertion.
- Reset mid-program:
  - Any pc value is abandoned.
  - After release, execution restarts at pc0 with the same sequence.
  - No partial or stale value is ever shown.
- Reset released coincident with an edge: that edge performs no execute. The first execute occurs on the next edge.
- Steady state: no stall and no idle cycles. Exactly one instruction executes per clock.

## Structure
- Shared package `operation_pkg` holds:
  - the opcode enum/localparams (3-bit);
  - the instruction struct `{opcode, imm}`;
  - `DATA_W=8` and `PROG_DEPTH=8`;
  - the program ROM contents as a constant array.
- Sub-module `operation_alu` is purely combinational:
  - Inputs: opcode, acc, imm.
  - Output: next acc value.
  - The `case` over opcodes lives here.
- Top module owns `pc`, `acc`, the ROM lookup and the reset logic. Target roughly 120–160 lines total.

## Test plan
- Reset hold: assert `reset` for 5 cycles → `po_a`=0x00 throughout, with no change on clock edges.
- Program sequence: release reset between edges → the next 8 edges yield 05, 03, 06, FF, F0, FA, 38, 1C.
- Wrap: run 24 edges after release → edges 9 and 17 both yield 05, and the full sequence repeats three times identically.
- Arithmetic wrap: check edge 2 = 0x03 (0x05+0xFE carry dropped) and edge 4 = 0xFF (0x06−0x07 borrow dropped).
- Async mid-program reset:
  - Assert `reset` between edges 4 and 5, while `po_a`=FF → `po_a`=00 immediately, before the next edge.
  - Release → the sequence restarts at 05.
- ALU unit check: drive `operation_alu` with acc=0x81 for each opcode and imm=0x0F → results:
  - LOAD 0F, ADD 90, SUB 72, AND 01, OR 8F, XOR 8E, SHL 02, SHR 40.
